// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: preamble/SFD, byte stream as LSB-first dibits, zero pad,
// CRC-32 FCS and inter-frame gap.
module rmii_tx_framer #(
  parameter int unsigned MIN_LEN        = 60,
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned IFG_CYCLES     = 48
) (
  input  logic       clk,
  input  logic       resn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_en,
  output logic [1:0] txd,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {StIdle, StPre, StData, StPad, StFcs, StIfg} state_e;

  localparam logic [15:0] PreLast = 16'(4 * (PREAMBLE_BYTES + 1) - 1);
  localparam logic [15:0] IfgLast = 16'(IFG_CYCLES - 1);
  localparam logic [10:0] CntMax  = 11'h7ff;

  state_e      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [15:0] tmr_q, tmr_d;
  logic [7:0]  hold_q, hold_d;
  logic        last_q, last_d;
  logic [10:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d;
  logic [1:0]  txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;
  logic        rdy_en_q;
  logic        byte_end;

  // Two reflected CRC-32 steps, bit 0 of the dibit first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 2; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hedb88320 : 32'h0);
    end
    return r;
  endfunction

  assign byte_end = (ph_q == 2'd3);
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 11'd1;

  // rdy_en_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = rdy_en_q;
      StData:  in_ready = byte_end && !last_q;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    tmr_d      = tmr_q;
    hold_d     = hold_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    underrun_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d = StPre;
          hold_d  = in_data;
          last_d  = in_last;
          cnt_d   = '0;
          crc_d   = '1;
          tmr_d   = '0;
          ph_d    = '0;
        end
      end
      StPre: begin
        tmr_d = tmr_q + 16'd1;
        if (tmr_q == PreLast) begin
          state_d = StData;
          tmr_d   = '0;
          ph_d    = '0;
        end
      end
      StData: begin
        crc_d = crc_dibit(crc_q, txd_q);
        ph_d  = ph_q + 2'd1;
        if (byte_end) begin
          cnt_d = cnt_inc;
          tmr_d = '0;
          if (last_q) begin
            state_d = (32'(cnt_inc) < MIN_LEN) ? StPad : StFcs;
          end else if (in_valid) begin
            hold_d = in_data;
            last_d = in_last;
          end else begin
            underrun_d = 1'b1;
            state_d    = StIfg;
          end
        end
      end
      StPad: begin
        crc_d = crc_dibit(crc_q, 2'b00);
        ph_d  = ph_q + 2'd1;
        if (byte_end) begin
          cnt_d = cnt_inc;
          if (32'(cnt_inc) >= MIN_LEN) begin
            state_d = StFcs;
            tmr_d   = '0;
          end
        end
      end
      StFcs: begin
        tmr_d = tmr_q + 16'd1;
        if (tmr_q == 16'd15) begin
          state_d = StIfg;
          tmr_d   = '0;
        end
      end
      StIfg: begin
        tmr_d = tmr_q + 16'd1;
        if (tmr_q == IfgLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so the wire shows the dibit the
  // state register describes.
  always_comb begin
    tx_en_d = 1'b0;
    txd_d   = 2'b00;
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StPre: begin
        tx_en_d = 1'b1;
        txd_d   = (tmr_d == PreLast) ? 2'b11 : 2'b01;
      end
      StData: begin
        tx_en_d = 1'b1;
        unique case (ph_d)
          2'd0:    txd_d = hold_d[1:0];
          2'd1:    txd_d = hold_d[3:2];
          2'd2:    txd_d = hold_d[5:4];
          default: txd_d = hold_d[7:6];
        endcase
      end
      StPad: tx_en_d = 1'b1;
      StFcs: begin
        tx_en_d = 1'b1;
        txd_d   = ~crc_d[{tmr_d[3:0], 1'b0} +: 2];
      end
      default: begin
        tx_en_d = 1'b0;
        txd_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q    <= StIdle;
      ph_q       <= '0;
      tmr_q      <= '0;
      hold_q     <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      crc_q      <= '1;
      tx_en_q    <= 1'b0;
      txd_q      <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      tmr_q      <= tmr_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign tx_en    = tx_en_q;
  assign txd      = txd_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Directed bench for rmii_tx_framer: captures the RMII wire and checks framing,
// padding, FCS, underrun, back-to-back gap and reset recovery.
module tb_rmii_tx_framer;

  logic       clk;
  logic       resn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       tx_en;
  logic [1:0] txd;
  logic       busy;
  logic       underrun;

  rmii_tx_framer dut (
    .clk      (clk),
    .resn     (resn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_en    (tx_en),
    .txd      (txd),
    .busy     (busy),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [1:0] wire_q[$];
  logic [1:0] ref_q[$];
  int fstart[$];
  int flen[$];
  int gaps[$];
  int run_en, low_run, ifg_run, ur_cnt, rdy_cnt, rdy_bad, rdy_last;
  bit en_prev;
  bit abort;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int kind, input int i);
    logic [31:0] v;
    case (kind)
      1:       v = 32'(i * 7 + 3);
      2:       v = 32'(255 - i);
      default: v = 32'(i);
    endcase
    return v[7:0];
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hedb88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] wbyte(input int idx);
    return {wire_q[idx + 3], wire_q[idx + 2], wire_q[idx + 1], wire_q[idx]};
  endfunction

  // Wire monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (tx_en) begin
      if (!en_prev) begin
        fstart.push_back(wire_q.size());
        if (flen.size() > 0) gaps.push_back(low_run);
        run_en = 0;
      end
      wire_q.push_back(txd);
      run_en++;
    end else begin
      if (en_prev) begin
        flen.push_back(run_en);
        low_run = 0;
      end
      low_run++;
    end
    en_prev = tx_en;
    if (busy && !tx_en) ifg_run++;
    if (underrun) ur_cnt++;
    if (busy && in_ready) begin
      if (rdy_cnt > 0 && cyc - rdy_last != 4) rdy_bad++;
      rdy_cnt++;
      rdy_last = cyc;
    end
  end

  task automatic clear_mon();
    wire_q.delete();
    fstart.delete();
    flen.delete();
    gaps.delete();
    run_en  = 0;
    low_run = 0;
    ifg_run = 0;
    ur_cnt  = 0;
    rdy_cnt = 0;
    rdy_bad = 0;
    en_prev = tx_en;
  endtask

  // Offer n bytes; stop_at >= 0 withholds data from that byte on.
  task automatic send(input int n, input int kind, input int stop_at);
    bit got;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) begin
        in_valid = 1'b0;
        return;
      end
      in_data  = pat(kind, i);
      in_last  = (i == n - 1);
      in_valid = 1'b1;
      got      = 1'b0;
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        if (abort) break;
        if (in_ready) begin
          @(posedge clk);
          #1;
          got = 1'b1;
          break;
        end
      end
      if (abort) return;
      if (!got) begin
        chk("accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int idx, input int kind, input int n);
    int          st, ntot, o, pbad, dbad;
    logic [31:0] c, r, fcs;
    logic [7:0]  e;
    if (idx >= fstart.size() || idx >= flen.size()) begin
      chk({tag, "_missing"}, 32'd0, 32'd1);
      return;
    end
    ntot = (n < 60) ? 60 : n;
    st   = fstart[idx];
    chk({tag, "_len"}, flen[idx], 32 + 4 * ntot + 16);
    if (flen[idx] != 32 + 4 * ntot + 16) return;
    pbad = 0;
    for (int k = 0; k < 32; k++) begin
      if (wire_q[st + k] !== ((k == 31) ? 2'b11 : 2'b01)) pbad++;
    end
    chk({tag, "_preamble_errs"}, pbad, 0);
    dbad = 0;
    c    = 32'hffffffff;
    for (int b = 0; b < ntot; b++) begin
      e = (b < n) ? pat(kind, b) : 8'h00;
      if (wbyte(st + 32 + 4 * b) !== e) dbad++;
      c = crc_byte(c, e);
    end
    chk({tag, "_data_errs"}, dbad, 0);
    o   = st + 32 + 4 * ntot;
    fcs = {wbyte(o + 12), wbyte(o + 8), wbyte(o + 4), wbyte(o)};
    chk({tag, "_fcs"}, fcs, ~c);
    r = c;
    for (int j = 0; j < 4; j++) r = crc_byte(r, wbyte(o + 4 * j));
    chk({tag, "_residue"}, r, 32'hdebb20e3);
  endtask

  initial begin
    int          dbad;
    logic [15:0] pk;
    resn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    abort    = 1'b0;

    // Reset state.
    #15;
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_txd", 32'(txd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 resn = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rdy_after_edge", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Minimum frame: 42 bytes padded to 60.
    clear_mon();
    send(42, 1, -1);
    in_valid = 1'b0;
    wait_idle();
    check_frame("min", 0, 1, 42);
    chk("min_ready_pulses", rdy_cnt, 41);
    chk("min_ready_spacing_errs", rdy_bad, 0);
    chk("min_ifg", ifg_run, 48);
    chk("min_no_underrun", ur_cnt, 0);

    // Unpadded 64-byte frame.
    clear_mon();
    send(64, 0, -1);
    in_valid = 1'b0;
    wait_idle();
    check_frame("full", 0, 0, 64);
    pk = '0;
    if (wire_q.size() >= 40) begin
      for (int k = 0; k < 8; k++) pk[2 * k +: 2] = wire_q[32 + k];
    end
    chk("full_first_dibits", 32'(pk), 32'h0100);
    ref_q = wire_q;

    // Underrun at byte 20.
    clear_mon();
    send(64, 0, 20);
    in_valid = 1'b0;
    wait_idle();
    chk("ur_frames", flen.size(), 1);
    chk("ur_len", (flen.size() > 0) ? flen[0] : 0, 112);
    chk("ur_wire_dibits", wire_q.size(), 112);
    dbad = 0;
    if (wire_q.size() >= 112) begin
      for (int b = 0; b < 20; b++) if (wbyte(32 + 4 * b) !== pat(0, b)) dbad++;
    end
    chk("ur_data_errs", dbad, 0);
    chk("ur_pulses", ur_cnt, 1);
    chk("ur_ifg", ifg_run, 48);

    // Back-to-back frames with in_valid held high.
    clear_mon();
    send(60, 0, -1);
    send(60, 2, -1);
    in_valid = 1'b0;
    wait_idle();
    check_frame("b2b_a", 0, 0, 60);
    check_frame("b2b_b", 1, 2, 60);
    chk("b2b_gaps", gaps.size(), 1);
    chk("b2b_gap", (gaps.size() > 0) ? gaps[0] : 0, 49);

    // Reset in the middle of DATA, then a fresh frame.
    clear_mon();
    fork
      send(64, 0, -1);
    join_none
    repeat (60) @(posedge clk);
    #2;
    chk("mid_tx_en_before", 32'(tx_en), 32'd1);
    resn = 1'b0;
    #1;
    chk("mid_rst_tx_en", 32'(tx_en), 32'd0);
    chk("mid_rst_txd", 32'(txd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    abort    = 1'b0;
    resn     = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    send(64, 0, -1);
    in_valid = 1'b0;
    wait_idle();
    chk("post_rst_size", wire_q.size(), ref_q.size());
    dbad = 0;
    if (wire_q.size() == ref_q.size()) begin
      foreach (ref_q[k]) if (wire_q[k] !== ref_q[k]) dbad++;
    end
    chk("post_rst_bit_errs", dbad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
